// File: rtl/fetch_unit_pkg.sv
// Shared constants for the F-stage fetch unit: exception codes, branch/jump opcodes,
// text segment bounds, FSM state encoding and the F-stage address check.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned EXC_W = 5;
  localparam int unsigned OP_W = 6;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM  = 6'h01;
  localparam logic [OP_W-1:0] OP_J       = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE     = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ    = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ    = 6'h07;

  localparam logic [OP_W-1:0] FUNCT_JR   = 6'h08;
  localparam logic [OP_W-1:0] FUNCT_JALR = 6'h09;

  localparam logic [XLEN-1:0] TEXT_BASE = 32'h0000_3000;
  localparam logic [XLEN-1:0] TEXT_LAST = 32'h0000_6FFC;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  // Misaligned or outside the text segment.
  function automatic logic addr_fault(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr < TEXT_BASE) || (addr > TEXT_LAST);
  endfunction

endpackage

// File: rtl/branch_detect.sv
// Classifies an instruction (opcode/funct fields) as a branch or jump, i.e. one that
// owns a delay slot.
module branch_detect
  import fetch_unit_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  output logic            is_branch_c
);

  always_comb begin
    is_branch_c = 1'b0;
    unique case (opcode)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM, OP_J, OP_JAL: is_branch_c = 1'b1;
      OP_SPECIAL: is_branch_c = (funct == FUNCT_JR) || (funct == FUNCT_JALR);
      default:    is_branch_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// F-stage fetch unit: PC register, next-PC select, level req/ack handshake with
// instruction memory and optional address fault check (FETCH_ADDR_CHECK_EN).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             req,
  input  logic             eret,
  input  logic [XLEN-1:0]  epc,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             imem_ack,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  output logic             out_is_delay,
  output logic [EXC_W-1:0] out_exc_code,
  output logic             fetch_busy
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ibuf;
  logic            is_delay;

  logic            fault;
  logic            ack_v;
  logic            advance;
  logic            is_branch_c;
  logic [XLEN-1:0] next_pc;

`ifdef FETCH_ADDR_CHECK_EN
  assign fault = addr_fault(pc);
`else
  assign fault = 1'b0;
`endif

  // A faulted PC issues no request, so any stray ack is ignored.
  assign ack_v   = imem_ack && (state == FETCH) && !fault;
  assign advance = !stall && ((state == HOLD) || ack_v);
  assign next_pc = branch_taken ? branch_target : pc + XLEN'(4);

  assign imem_req     = (state == FETCH) && !fault;
  assign imem_addr    = pc;
  assign fetch_busy   = (state == FETCH) && !fault && !imem_ack;
  assign out_pc       = pc;
  assign out_is_delay = is_delay && !eret;
  assign out_exc_code = (fault && !eret) ? EXC_ADEL : EXC_NONE;

  always_comb begin
    out_instr = (state == HOLD) ? ibuf : imem_rdata;
    if (fault || eret) out_instr = '0;
  end

  branch_detect u_branch_detect (
    .opcode      (out_instr[31:26]),
    .funct       (out_instr[5:0]),
    .is_branch_c (is_branch_c)
  );

  // PC, state, instruction buffer and delay-slot flag; reset > req > eret > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      ibuf     <= '0;
      is_delay <= 1'b0;
    end else if (req) begin
      pc       <= EXC_VECTOR;
      state    <= FETCH;
      ibuf     <= '0;
      is_delay <= 1'b0;
    end else if (eret) begin
      pc       <= epc;
      state    <= FETCH;
      ibuf     <= '0;
      is_delay <= 1'b0;
    end else if (stall) begin
      if (ack_v) begin
        ibuf  <= imem_rdata;
        state <= HOLD;
      end
    end else if (advance) begin
      pc       <= next_pc;
      state    <= FETCH;
      is_delay <= is_branch_c;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

F-stage fetch unit for the P7 pipelined MIPS CPU. Holds the PC, selects the next PC, runs a level request/acknowledge handshake with instruction memory, and flags F-stage address exceptions. Drives the IF/ID pipeline register's `in_PC`, `in_instruction`, `in_IsDelay` and `in_F_ExcCode`, and owns the exception-vector and ERET redirects.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.
- `EXC_VECTOR`, default 32'h0000_4180: PC loaded on `req`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: hazard-unit stall. The hazard unit ORs `fetch_busy` into it.
- `req` in 1: exception or interrupt taken; redirect to `EXC_VECTOR`.
- `eret` in 1: ERET in D; redirect to `epc`.
- `epc` in 32: return address from CP0.
- `branch_taken` in 1: branch or jump resolved taken in D.
- `branch_target` in 32: resolved target.
- `imem_req` out 1: fetch request, level.
- `imem_addr` out 32: fetch address; equals the PC.
- `imem_rdata` in 32: instruction; valid only while `imem_ack` is high.
- `imem_ack` in 1: data valid this cycle. May come in the same cycle as `imem_req` or later.
- `out_pc` out 32: PC of the F instruction.
- `out_instr` out 32: F instruction; 0 (nop) when killed or faulted.
- `out_is_delay` out 1: F instruction is a delay slot.
- `out_exc_code` out 5: F-stage ExcCode.
- `fetch_busy` out 1: instruction not yet available.

## Operation
- Two states:
  - FETCH: `imem_req` is 1 unless the PC faults.
  - HOLD: instruction already captured in `ibuf`; `imem_req` is 0.
- PC update priority: `reset` > `req` > `eret` > `stall` > `branch_taken` > PC+4.
  - `req` or `eret`: PC ← `EXC_VECTOR` or `epc`; state ← FETCH; `ibuf` dropped; `is_delay` ← 0.
  - `stall` high: PC held.
  - Advance (`stall` low): PC ← `branch_taken` ? `branch_target` : PC+4, 32-bit wrap.
- FETCH behaviour:
  - `imem_ack` and no `stall`: advance, stay in FETCH.
  - `imem_ack` and `stall`: `ibuf` ← `imem_rdata`, go to HOLD.
  - No `imem_ack`: `fetch_busy`=1, PC held.
- HOLD behaviour:
  - `out_instr` = `ibuf`.
  - On `stall` low: advance, go to FETCH.
- `out_instr` = `imem_rdata` in FETCH, `ibuf` in HOLD, and 0 when faulted or when `eret`=1.
- Delay slot tracking:
  - On every advance: `is_delay` ← (`out_instr` is a branch or jump).
  - Branch or jump means opcode beq, bne, blez, bgtz, bltz/bgez (REGIMM), j or jal; or SPECIAL with funct jr or jalr.
  - `out_is_delay` = `is_delay`, forced to 0 while `eret`=1.
- Fault check, when `FETCH_ADDR_CHECK_EN` is defined:
  - Fault condition: PC[1:0] ≠ 0, or PC outside [0x3000, 0x6FFC].
  - On fault: `out_exc_code` = `EXC_ADEL`, `imem_req`=0, `fetch_busy`=0, `out_instr`=0.
  - Otherwise `out_exc_code` = `EXC_NONE`.
- `eret` kill: `out_instr`=0, `out_exc_code`=`EXC_NONE`, `out_is_delay`=0. ERET has no delay slot.

## Timing
- Reset values:
  - PC = `RESET_PC`; state = FETCH; `is_delay`=0; `ibuf`=0.
  - Hence `out_pc`=0x3000, `imem_addr`=0x3000, `imem_req`=1, `out_exc_code`=`EXC_NONE`, `out_is_delay`=0.
- Zero-wait memory (ack in the same cycle): one instruction per cycle; `fetch_busy` stays 0.
- N-wait memory: `fetch_busy`=1 for N cycles, then the instruction is presented.
- `imem_req` is combinational from state and PC. Memory must tolerate withdrawal of the request (on redirect) and keeps no outstanding transaction.
- `req` or `eret` during a wait: the pending fetch is abandoned, and the new PC is presented in the next cycle.
- `req` and `eret` together: `req` wins.
- `reset` mid-wait or mid-HOLD: all reset values in the next cycle.
- `branch_taken` is sampled only on an advance cycle. While stalled, D holds the branch, so it is re-presented.
- Misaligned `epc`: the fault is flagged in the cycle after the redirect.

## Configuration
- `FETCH_ADDR_CHECK_EN`:
  - Defined: alignment and range check as above.
  - Undefined: no F-stage fault; `out_exc_code` is always `EXC_NONE`; `imem_req` is 1 in FETCH for any PC.

## Structure
- Constants belong in the shared `define.v`:
  - `EXC_NONE` (5'd0) and `EXC_ADEL` (5'd4).
  - Opcode and funct codes for the branch/jump set.
  - `TEXT_BASE` 0x3000 and `TEXT_LAST` 0x6FFC.
  - State encodings FETCH and HOLD.
- One sub-module: `branch_detect`, a combinational classifier mapping an instruction to its is-branch-or-jump bit.

## Test plan
- Reset, then zero-wait memory returning 0 → `out_pc` runs 0x3000, 0x3004, 0x3008 on consecutive cycles; `fetch_busy`=0.
- Memory acks 2 cycles late at 0x3000 → `fetch_busy`=1 for 2 cycles, then `out_instr` = `imem_rdata`; PC advances the following cycle.
- Ack with `stall`=1 for 3 cycles, then `imem_rdata` changes → `imem_req`=0 and `out_instr` holds the captured word; PC is 0x3004 after the stall releases.
- F instruction 0x10000003 (beq) advances; then `branch_taken`=1 with target 0x3100 → next `out_is_delay`=1; the cycle after, `out_pc`=0x3100 and `out_is_delay`=0.
- `req` during a wait, with `eret` also high → next `out_pc`=0x4180. Separately, `eret` alone with `epc`=0x3010 → `out_instr`=0 that cycle, and next `out_pc`=0x3010.
- With `FETCH_ADDR_CHECK_EN`, `epc`=0x3002 → after ERET, `out_exc_code`=4, `imem_req`=0, `out_instr`=0. The same at `branch_target`=0x7000.
